// File: rtl/arbiter_wrr_lock.sv
// Weighted round-robin arbiter with per-transaction grant lock, per-requester credits and a hold timeout.
// Grant is registered, one cycle after a request is seen in IDLE; the owner keeps it until done, a dropped req, or MAX_HOLD.
module arbiter_wrr_lock #(
    parameter int N        = 4,
    parameter int WW       = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 done,
    input  logic [N*WW-1:0]      weight,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 timeout
);
    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] credit     [N];
    logic [WW-1:0] credit_nxt [N];
    logic [WW-1:0] wt         [N];
    logic [IW-1:0] ptr, ptr_nxt, id_nxt, win;
    logic [HW-1:0] hold, hold_nxt;
    logic [N-1:0]  grant_nxt, elig_raw, elig;
    logic          timeout_nxt, reload, found;

    // A zero weight still gets one grant per round.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            wt[i] = (weight[i*WW +: WW] == '0) ? WW'(1) : weight[i*WW +: WW];
            elig_raw[i] = req[i] && (credit[i] != '0);
        end
        reload = (elig_raw == '0);
        elig   = reload ? req : elig_raw;
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!found && elig[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                win   = IW'((int'(ptr) + k) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            timeout  <= 1'b0;
            ptr      <= IW'(N - 1);
            hold     <= '0;
            for (int i = 0; i < N; i++) credit[i] <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            grant_id <= id_nxt;
            timeout  <= timeout_nxt;
            ptr      <= ptr_nxt;
            hold     <= hold_nxt;
            credit   <= credit_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        credit_nxt  = credit;
        ptr_nxt     = ptr;
        hold_nxt    = hold;
        grant_nxt   = grant;
        id_nxt      = grant_id;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                grant_nxt = '0;
                if (req != '0) begin
                    if (reload) begin
                        for (int i = 0; i < N; i++) credit_nxt[i] = wt[i];
                    end
                    grant_nxt = N'(1) << win;
                    id_nxt    = win;
                    hold_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // Completion and abandonment both cost exactly one credit.
                if (done || !req[grant_id]) begin
                    if (credit[grant_id] != '0) credit_nxt[grant_id] = credit[grant_id] - WW'(1);
                    ptr_nxt   = grant_id;
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end else if (hold == HW'(MAX_HOLD - 1)) begin
                    credit_nxt[grant_id] = '0;
                    ptr_nxt     = grant_id;
                    grant_nxt   = '0;
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    hold_nxt = hold + HW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == GRANT);
    end
endmodule

// File: tb/tb_arbiter_wrr_lock.sv
// Bench for arbiter_wrr_lock: directed scenarios plus a randomized run against a transaction-level model.
module tb_arbiter_wrr_lock;
    localparam int N    = 4;
    localparam int WW   = 4;
    localparam int MAXH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic          done = 1'b0;
    logic [N*WW-1:0] weight = '0;
    logic [N-1:0]  grant;
    logic [1:0]    grant_id;
    logic          busy;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the resource, for how long, and remaining credits.
    int m_cred [N];
    int m_owner = -1;
    int m_id = 0;
    int m_ptr = N - 1;
    int m_hold = 0;
    bit m_to = 1'b0;

    arbiter_wrr_lock #(.N(N), .WW(WW), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .weight(weight),
        .grant(grant), .grant_id(grant_id), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic int wof(int i);
        int w;
        w = int'(weight[i*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic model_step();
        int o;
        bit any;
        if (rst) begin
            m_owner = -1; m_id = 0; m_ptr = N - 1; m_hold = 0; m_to = 1'b0;
            for (int i = 0; i < N; i++) m_cred[i] = 0;
            return;
        end
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (req != '0) begin
                any = 1'b0;
                for (int i = 0; i < N; i++) if (req[i] && m_cred[i] > 0) any = 1'b1;
                if (!any) for (int i = 0; i < N; i++) m_cred[i] = wof(i);
                for (int k = N; k >= 1; k--) begin
                    o = (m_ptr + k) % N;
                    if (req[o] && m_cred[o] > 0) m_owner = o;
                end
                m_id = m_owner;
                m_hold = 0;
            end
        end else begin
            o = m_owner;
            if (done || !req[o]) begin
                m_cred[o] = (m_cred[o] > 0) ? m_cred[o] - 1 : 0;
                m_ptr = o; m_owner = -1;
            end else if (m_hold == MAXH - 1) begin
                m_cred[o] = 0; m_ptr = o; m_owner = -1; m_to = 1'b1;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; done = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        while (grant == '0 && cyc < 12) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; weight = '0;
        tick(); tick();
        checks++;
        if (grant !== 4'b0 || grant_id !== 2'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got grant=%b id=%0d busy=%b to=%b exp 0 0 0 0", grant, grant_id, busy, timeout);
        end
        req = '0;
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req got grant=%b busy=%b exp 0 0", grant, busy);
        end
    endtask

    task automatic run_grants(input string name, input int exp_ids[10], input int n);
        int cyc;
        for (int g = 0; g < n; g++) begin
            wait_grant(cyc);
            checks++;
            if (cyc !== 1 || grant !== (4'b1 << exp_ids[g]) || int'(grant_id) !== exp_ids[g] || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_grant%0d got grant=%b id=%0d wait=%0d exp id=%0d wait=1", name, g, grant, grant_id, cyc, exp_ids[g]);
            end
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (grant !== 4'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_release%0d got grant=%b busy=%b exp 0 0", name, g, grant, busy);
            end
        end
    endtask

    task automatic test_equal_weights();
        int ids[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        req = 4'b1111;
        do_reset();
        run_grants("t1", ids, 5);
    endtask

    task automatic test_weighted();
        int ids[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0};
        weight = {4'd1, 4'd1, 4'd1, 4'd2};
        req = 4'b1111;
        do_reset();
        run_grants("t2", ids, 10);
    endtask

    task automatic test_timeout();
        int cyc;
        weight = {4'd1, 4'd1, 4'd3, 4'd1};
        req = 4'b0100;
        do_reset();
        wait_grant(cyc);
        cyc = 0;
        while (grant == 4'b0100 && cyc < 20) begin
            cyc++;
            tick();
        end
        checks++;
        if (cyc !== MAXH || grant !== 4'b0 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL t3_timeout got held=%0d grant=%b to=%b exp held=%0d grant=0 to=1", cyc, grant, timeout, MAXH);
        end
        tick();
        checks++;
        if (timeout !== 1'b0 || grant !== 4'b0100 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL t3_regrant got grant=%b id=%0d to=%b exp 0100 2 0", grant, grant_id, timeout);
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_abandon();
        int cyc;
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        req = 4'b0011;
        do_reset();
        wait_grant(cyc);
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL t4_first got grant=%b exp 0001", grant);
        end
        tick(); tick();
        req = 4'b0010;
        tick();
        checks++;
        if (grant !== 4'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL t4_drop got grant=%b to=%b exp 0 0", grant, timeout);
        end
        tick();
        checks++;
        if (grant !== 4'b0010 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL t4_next got grant=%b id=%0d exp 0010 1", grant, grant_id);
        end
    endtask

    task automatic test_reset_mid_grant();
        int cyc;
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        req = 4'b1000;
        do_reset();
        wait_grant(cyc);
        checks++;
        if (grant !== 4'b1000 || grant_id !== 2'd3) begin
            errors++;
            $display("FAIL t5_grant got grant=%b id=%0d exp 1000 3", grant, grant_id);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL t5_reset got grant=%b busy=%b id=%0d exp 0 0 0", grant, busy, grant_id);
        end
        rst = 1'b0;
        req = 4'b1111;
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL t5_after got grant=%b exp 0001", grant);
        end
    endtask

    task automatic test_done_corners();
        int cyc;
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        req = '0;
        do_reset();
        done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (grant !== 4'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL t6_idle_done%0d got grant=%b busy=%b to=%b exp 0 0 0", i, grant, busy, timeout);
            end
        end
        done = 1'b0;
        req = 4'b0010;
        wait_grant(cyc);
        for (int i = 0; i < MAXH - 1; i++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (grant !== 4'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t6_done_vs_timeout got grant=%b to=%b busy=%b exp 0 0 0", grant, timeout, busy);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_g;
        int bad = 0;
        weight = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
        req = 4'($urandom);
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            if ($urandom_range(0, 199) == 0) weight = N*WW'($urandom);
            done = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0) rst = 1'b1; else rst = 1'b0;
            tick();
            exp_g = (m_owner < 0) ? 4'b0 : (4'b1 << m_owner);
            checks++;
            if (grant !== exp_g || int'(grant_id) !== m_id || busy !== (m_owner >= 0) ||
                timeout !== m_to || $countones(grant) > 1) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_cycle%0d got grant=%b id=%0d busy=%b to=%b exp grant=%b id=%0d busy=%b to=%b",
                             c, grant, grant_id, busy, timeout, exp_g, m_id, m_owner >= 0, m_to);
            end
        end
        rst = 1'b0;
        done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_equal_weights();
        test_weighted();
        test_timeout();
        test_abandon();
        test_reset_mid_grant();
        test_done_corners();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
